// File: rtl/mem_port_arbiter.sv
// Shares one external memory port between the instruction-fetch and data ports.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIM data grants.
module mem_port_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic            clk,
  input  logic            reset,
  // Instruction-fetch port
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_adr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [31:0]     if_rdata_o,
  // Data port
  input  logic            d_req_i,
  input  logic [XLEN-1:0] d_adr_i,
  input  logic            d_we_i,
  input  logic [2:0]      d_size_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  // Memory port
  output logic            mem_req_o,
  output logic [XLEN-1:0] mem_adr_o,
  output logic            mem_we_o,
  output logic [2:0]      mem_size_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            busy_o
);

  localparam int unsigned SW = (STARVE_LIM < 1) ? 1 : $clog2(STARVE_LIM + 1);
  localparam logic [SW-1:0] StarveMax = SW'(STARVE_LIM);

  typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;
  typedef enum logic {OwnData, OwnFetch} owner_e;

  state_e        state_q;
  owner_e        owner_q;
  logic [SW-1:0] starve_q;

  owner_e winner;
  logic   pending;
  logic   drive;
  logic   sel_fetch;

  assign pending = if_req_i | d_req_i;
  assign winner  = (if_req_i && (!d_req_i || starve_q == StarveMax)) ? OwnFetch : OwnData;

  // In IDLE the winner is chosen live; in REQ the latched owner keeps the port.
  always_comb begin
    drive     = 1'b0;
    sel_fetch = 1'b0;
    unique case (state_q)
      StIdle: begin
        drive     = pending;
        sel_fetch = (winner == OwnFetch);
      end
      StReq: begin
        drive     = 1'b1;
        sel_fetch = (owner_q == OwnFetch);
      end
      default: begin
        drive     = 1'b0;
        sel_fetch = (owner_q == OwnFetch);
      end
    endcase
  end

  always_comb begin
    mem_req_o   = 1'b0;
    mem_adr_o   = '0;
    mem_we_o    = 1'b0;
    mem_size_o  = 3'b000;
    mem_wdata_o = '0;
    if_gnt_o    = 1'b0;
    d_gnt_o     = 1'b0;
    if_rvalid_o = 1'b0;
    if_rdata_o  = '0;
    d_rvalid_o  = 1'b0;
    d_rdata_o   = '0;
    busy_o      = 1'b0;
    if (!reset) begin
      busy_o = (state_q != StIdle);
      if (drive) begin
        mem_req_o = 1'b1;
        if (sel_fetch) begin
          mem_adr_o  = if_adr_i;
          mem_size_o = 3'b010;
          if_gnt_o   = mem_gnt_i;
        end else begin
          mem_adr_o   = d_adr_i;
          mem_we_o    = d_we_i;
          mem_size_o  = d_size_i;
          mem_wdata_o = d_wdata_i;
          d_gnt_o     = mem_gnt_i;
        end
      end
      // Responses outside WAIT are protocol errors and are dropped.
      if (state_q == StWait && mem_rvalid_i) begin
        if (owner_q == OwnFetch) begin
          if_rvalid_o = 1'b1;
          if_rdata_o  = mem_rdata_i[31:0];
        end else begin
          d_rvalid_o = 1'b1;
          d_rdata_o  = mem_rdata_i;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StIdle;
      owner_q  <= OwnData;
      starve_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pending) begin
            owner_q <= winner;
            state_q <= mem_gnt_i ? StWait : StReq;
          end
        end
        StReq: begin
          if (mem_gnt_i) state_q <= StWait;
        end
        StWait: begin
          if (mem_rvalid_i) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
      if (if_gnt_o) begin
        starve_q <= '0;
      end else if (d_gnt_o && if_req_i && starve_q != StarveMax) begin
        starve_q <= starve_q + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level reference model.
module tb_mem_port_arbiter;
  localparam int unsigned XLEN   = 32;
  localparam int          LIM    = 4;
  localparam int          NCYC   = 4000;

  logic            clk = 1'b0;
  logic            reset;
  logic            if_req_i, if_gnt_o, if_rvalid_o;
  logic [XLEN-1:0] if_adr_i;
  logic [31:0]     if_rdata_o;
  logic            d_req_i, d_we_i, d_gnt_o, d_rvalid_o;
  logic [XLEN-1:0] d_adr_i, d_wdata_i, d_rdata_o;
  logic [2:0]      d_size_i;
  logic            mem_req_o, mem_we_o, mem_gnt_i, mem_rvalid_i, busy_o;
  logic [XLEN-1:0] mem_adr_o, mem_wdata_o, mem_rdata_i;
  logic [2:0]      mem_size_o;

  mem_port_arbiter #(.XLEN(XLEN), .STARVE_LIM(LIM)) dut (
    .clk(clk), .reset(reset),
    .if_req_i(if_req_i), .if_adr_i(if_adr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .d_req_i(d_req_i), .d_adr_i(d_adr_i), .d_we_i(d_we_i), .d_size_i(d_size_i),
    .d_wdata_i(d_wdata_i), .d_gnt_o(d_gnt_o), .d_rvalid_o(d_rvalid_o), .d_rdata_o(d_rdata_o),
    .mem_req_o(mem_req_o), .mem_adr_o(mem_adr_o), .mem_we_o(mem_we_o),
    .mem_size_o(mem_size_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", tag, $time, obs, exp);
    end
  endtask

  // Reference model: one transaction, either waiting for acceptance or for its response.
  bit  txn_open;      // a requester holds the port
  bit  txn_accepted;  // memory accepted, response outstanding
  bit  txn_fetch;     // owner of the open transaction
  bit  txn_store;
  int  data_wins;     // data grants since the last fetch grant while fetch waited

  bit              e_req, e_we, e_if_gnt, e_d_gnt, e_if_rv, e_d_rv, e_busy, e_pick;
  logic [XLEN-1:0] e_adr, e_wdata, e_if_rd, e_d_rd;
  logic [2:0]      e_size;

  task automatic model_outputs();
    bit issuing;
    e_req = 0; e_we = 0; e_if_gnt = 0; e_d_gnt = 0; e_if_rv = 0; e_d_rv = 0; e_busy = 0;
    e_adr = '0; e_wdata = '0; e_if_rd = '0; e_d_rd = '0; e_size = 3'b000; e_pick = 0;
    if (reset) return;
    e_busy  = txn_open;
    issuing = 0;
    if (!txn_open && (if_req_i || d_req_i)) begin
      issuing = 1;
      e_pick  = if_req_i && (!d_req_i || data_wins == LIM);
    end else if (txn_open && !txn_accepted) begin
      issuing = 1;
      e_pick  = txn_fetch;
    end
    if (issuing) begin
      e_req = 1;
      if (e_pick) begin
        e_adr = if_adr_i; e_size = 3'b010; e_if_gnt = mem_gnt_i;
      end else begin
        e_adr = d_adr_i; e_we = d_we_i; e_size = d_size_i; e_wdata = d_wdata_i;
        e_d_gnt = mem_gnt_i;
      end
    end
    if (txn_open && txn_accepted && mem_rvalid_i) begin
      if (txn_fetch) begin e_if_rv = 1; e_if_rd = mem_rdata_i; end
      else begin e_d_rv = 1; e_d_rd = mem_rdata_i; end
    end
  endtask

  task automatic model_step();
    if (reset) begin
      txn_open = 0; txn_accepted = 0; txn_fetch = 0; data_wins = 0;
      return;
    end
    if (e_if_gnt) data_wins = 0;
    else if (e_d_gnt && if_req_i && data_wins < LIM) data_wins++;
    if (e_d_gnt) txn_store = d_we_i;
    if (!txn_open) begin
      if (if_req_i || d_req_i) begin
        txn_open = 1; txn_fetch = e_pick; txn_accepted = mem_gnt_i;
      end
    end else if (!txn_accepted) begin
      if (mem_gnt_i) txn_accepted = 1;
    end else if (mem_rvalid_i) begin
      txn_open = 0; txn_accepted = 0;
    end
  endtask

  bit if_pend, d_pend;

  initial begin
    reset = 1; if_req_i = 0; if_adr_i = '0; d_req_i = 0; d_adr_i = '0; d_we_i = 0;
    d_size_i = 3'b000; d_wdata_i = '0; mem_gnt_i = 0; mem_rvalid_i = 0; mem_rdata_i = '0;
    if_pend = 0; d_pend = 0; txn_open = 0; txn_accepted = 0; txn_fetch = 0;
    txn_store = 0; data_wins = 0;
    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      reset = (cyc < 2) || ($urandom_range(99) < 2);
      if (!if_pend && $urandom_range(99) < 60) begin
        if_pend = 1; if_adr_i = {$urandom} & 32'hffff_fffc;
      end
      if (!d_pend && $urandom_range(99) < 70) begin
        d_pend = 1; d_adr_i = $urandom; d_we_i = 1'($urandom);
        d_size_i = 3'($urandom_range(2)); d_wdata_i = $urandom;
      end
      if_req_i     = if_pend;
      d_req_i      = d_pend;
      mem_gnt_i    = 1'($urandom);
      mem_rvalid_i = ($urandom_range(99) < 40);
      // Store responses carry no data.
      mem_rdata_i  = (txn_accepted && !txn_fetch && txn_store) ? '0 : $urandom;
      #1;
      model_outputs();
      check("mem_req",   32'(mem_req_o),   32'(e_req));
      check("mem_adr",   mem_adr_o,        e_adr);
      check("mem_we",    32'(mem_we_o),    32'(e_we));
      check("mem_size",  32'(mem_size_o),  32'(e_size));
      check("mem_wdata", mem_wdata_o,      e_wdata);
      check("if_gnt",    32'(if_gnt_o),    32'(e_if_gnt));
      check("d_gnt",     32'(d_gnt_o),     32'(e_d_gnt));
      check("if_rvalid", 32'(if_rvalid_o), 32'(e_if_rv));
      check("if_rdata",  if_rdata_o,       e_if_rd);
      check("d_rvalid",  32'(d_rvalid_o),  32'(e_d_rv));
      check("d_rdata",   d_rdata_o,        e_d_rd);
      check("busy",      32'(busy_o),      32'(e_busy));
      @(posedge clk);
      model_step();
      if (e_if_gnt) if_pend = 0;
      if (e_d_gnt)  d_pend  = 0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
